// File: rtl/rv_commit_trace.sv
// Commit-trace generator at the WB end of rv_pipelined: registers the retiring
// instruction's architectural effects, keeps CPI counters, detects halt/timeout.
module rv_commit_trace #(
    parameter int unsigned XLEN          = 32,
    parameter int unsigned CntW          = 64,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            ret_valid_i,
    input  logic [XLEN-1:0] ret_pc_i,
    input  logic [XLEN-1:0] ret_instr_i,
    input  logic [4:0]      ret_rd_i,
    input  logic [XLEN-1:0] ret_rd_data_i,
    input  logic [XLEN-1:0] ret_mem_addr_i,
    input  logic [XLEN-1:0] ret_store_data_i,
    output logic            update_o,
    output logic [XLEN-1:0] pc_o,
    output logic [XLEN-1:0] instr_o,
    output logic [4:0]      reg_addr_o,
    output logic [XLEN-1:0] reg_data_o,
    output logic [XLEN-1:0] mem_addr_o,
    output logic [XLEN-1:0] mem_data_o,
    output logic            mem_wrt_o,
    output logic            mem_read_o,
    output logic [CntW-1:0] cycle_cnt_o,
    output logic [CntW-1:0] instret_cnt_o,
    output logic            halted_o,
    output logic            timeout_o
);
    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam int unsigned IdleW   = $clog2(TimeoutCycles + 1);

    typedef enum logic [1:0] {StRun, StHalted, StTimeout} state_e;

    state_e            state_q, state_d;
    logic [IdleW-1:0]  idle_q, idle_d;
    logic              update_q, update_d;
    logic [XLEN-1:0]   pc_q, pc_d, instr_q, instr_d;
    logic [4:0]        reg_addr_q, reg_addr_d;
    logic [XLEN-1:0]   reg_data_q, reg_data_d;
    logic [XLEN-1:0]   mem_addr_q, mem_addr_d, mem_data_q, mem_data_d;
    logic              mem_wrt_q, mem_wrt_d, mem_read_q, mem_read_d;
    logic [CntW-1:0]   cycle_q, cycle_d, instret_q, instret_d;
    logic              halted_q, halted_d, timeout_q, timeout_d;

    logic [6:0]        opcode;
    logic [2:0]        funct3;
    logic [XLEN-1:0]   rd_data_gated;
    logic [XLEN-1:0]   store_masked;

    assign opcode        = ret_instr_i[6:0];
    assign funct3        = ret_instr_i[14:12];
    assign rd_data_gated = (ret_rd_i == 5'd0) ? '0 : ret_rd_data_i;

    always_comb begin
        store_masked = '0;
        case (funct3)
            3'b000:  store_masked = {{(XLEN-8){1'b0}},  ret_store_data_i[7:0]};
            3'b001:  store_masked = {{(XLEN-16){1'b0}}, ret_store_data_i[15:0]};
            3'b010:  store_masked = ret_store_data_i;
            default: store_masked = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        idle_d     = idle_q;
        update_d   = 1'b0;
        pc_d       = pc_q;
        instr_d    = instr_q;
        reg_addr_d = reg_addr_q;
        reg_data_d = reg_data_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wrt_d  = mem_wrt_q;
        mem_read_d = mem_read_q;
        cycle_d    = cycle_q;
        instret_d  = instret_q;
        halted_d   = halted_q;
        timeout_d  = timeout_q;

        if (state_q == StRun) begin
            cycle_d = cycle_q + 1'b1;
            if (ret_valid_i) begin
                idle_d = '0;
                if (ret_instr_i == '0) begin
                    // Zero word ends the program; checked before the watchdog so HALTED wins.
                    state_d  = StHalted;
                    halted_d = 1'b1;
                    instr_d  = '0;
                end else begin
                    update_d   = 1'b1;
                    instret_d  = instret_q + 1'b1;
                    pc_d       = ret_pc_i;
                    instr_d    = ret_instr_i;
                    reg_addr_d = ret_rd_i;
                    reg_data_d = rd_data_gated;
                    mem_addr_d = '0;
                    mem_data_d = '0;
                    mem_wrt_d  = 1'b0;
                    mem_read_d = 1'b0;
                    case (opcode)
                        OpStore: begin
                            reg_addr_d = '0;
                            reg_data_d = '0;
                            mem_wrt_d  = 1'b1;
                            mem_addr_d = ret_mem_addr_i;
                            mem_data_d = store_masked;
                        end
                        OpLoad: begin
                            mem_read_d = 1'b1;
                            mem_addr_d = ret_mem_addr_i;
                        end
                        OpBranch: begin
                            reg_addr_d = '0;
                            reg_data_d = '0;
                        end
                        default: ;
                    endcase
                end
            end else begin
                idle_d = idle_q + 1'b1;
                if (idle_q == IdleW'(TimeoutCycles - 1)) begin
                    state_d   = StTimeout;
                    timeout_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q    <= StRun;
            idle_q     <= '0;
            update_q   <= 1'b0;
            pc_q       <= '0;
            instr_q    <= '0;
            reg_addr_q <= '0;
            reg_data_q <= '0;
            mem_addr_q <= '0;
            mem_data_q <= '0;
            mem_wrt_q  <= 1'b0;
            mem_read_q <= 1'b0;
            cycle_q    <= '0;
            instret_q  <= '0;
            halted_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idle_q     <= idle_d;
            update_q   <= update_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            reg_addr_q <= reg_addr_d;
            reg_data_q <= reg_data_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
            mem_wrt_q  <= mem_wrt_d;
            mem_read_q <= mem_read_d;
            cycle_q    <= cycle_d;
            instret_q  <= instret_d;
            halted_q   <= halted_d;
            timeout_q  <= timeout_d;
        end
    end

    assign update_o      = update_q;
    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign reg_addr_o    = reg_addr_q;
    assign reg_data_o    = reg_data_q;
    assign mem_addr_o    = mem_addr_q;
    assign mem_data_o    = mem_data_q;
    assign mem_wrt_o     = mem_wrt_q;
    assign mem_read_o    = mem_read_q;
    assign cycle_cnt_o   = cycle_q;
    assign instret_cnt_o = instret_q;
    assign halted_o      = halted_q;
    assign timeout_o     = timeout_q;
endmodule

// File: tb/tb_rv_commit_trace.sv
// Directed self-checking bench for rv_commit_trace with an 8-cycle watchdog.
module tb_rv_commit_trace;
    logic        clk = 1'b0;
    logic        rstn;
    logic        ret_valid;
    logic [31:0] ret_pc, ret_instr, ret_rd_data, ret_mem_addr, ret_store_data;
    logic [4:0]  ret_rd;
    logic        update, mem_wrt, mem_read, halted, timeout;
    logic [31:0] pc, instr, reg_data, mem_addr, mem_data;
    logic [4:0]  reg_addr;
    logic [63:0] cycle_cnt, instret_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    rv_commit_trace #(.XLEN(32), .CntW(64), .TimeoutCycles(8)) dut (
        .clk_i(clk), .rstn_i(rstn),
        .ret_valid_i(ret_valid), .ret_pc_i(ret_pc), .ret_instr_i(ret_instr),
        .ret_rd_i(ret_rd), .ret_rd_data_i(ret_rd_data),
        .ret_mem_addr_i(ret_mem_addr), .ret_store_data_i(ret_store_data),
        .update_o(update), .pc_o(pc), .instr_o(instr),
        .reg_addr_o(reg_addr), .reg_data_o(reg_data),
        .mem_addr_o(mem_addr), .mem_data_o(mem_data),
        .mem_wrt_o(mem_wrt), .mem_read_o(mem_read),
        .cycle_cnt_o(cycle_cnt), .instret_cnt_o(instret_cnt),
        .halted_o(halted), .timeout_o(timeout)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] p, input logic [31:0] i,
                         input logic [4:0] rd, input logic [31:0] rdd,
                         input logic [31:0] a, input logic [31:0] sd);
        ret_valid = v; ret_pc = p; ret_instr = i; ret_rd = rd;
        ret_rd_data = rdd; ret_mem_addr = a; ret_store_data = sd;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
    endtask

    task automatic check_zero(input string tag);
        check_eq({tag, "_update"}, update, 0);
        check_eq({tag, "_pc"}, pc, 0);
        check_eq({tag, "_instr"}, instr, 0);
        check_eq({tag, "_raddr"}, reg_addr, 0);
        check_eq({tag, "_rdata"}, reg_data, 0);
        check_eq({tag, "_maddr"}, mem_addr, 0);
        check_eq({tag, "_mdata"}, mem_data, 0);
        check_eq({tag, "_mwrt"}, mem_wrt, 0);
        check_eq({tag, "_mread"}, mem_read, 0);
        check_eq({tag, "_cycle"}, cycle_cnt, 0);
        check_eq({tag, "_instret"}, instret_cnt, 0);
        check_eq({tag, "_halted"}, halted, 0);
        check_eq({tag, "_timeout"}, timeout, 0);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        idle();
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        rstn = 1'b0;
        idle();
        #2;
        do_reset();
        check_zero("rst");

        // Store masking
        drive(1'b1, 32'h1000, 32'h00B50023, 5'd5, 32'h55, 32'h100, 32'hDEADBEEF);
        step();
        check_eq("sb_update", update, 1);
        check_eq("sb_wrt", mem_wrt, 1);
        check_eq("sb_read", mem_read, 0);
        check_eq("sb_addr", mem_addr, 32'h100);
        check_eq("sb_data", mem_data, 32'h000000EF);
        check_eq("sb_raddr", reg_addr, 0);
        check_eq("sb_rdata", reg_data, 0);
        check_eq("sb_pc", pc, 32'h1000);
        check_eq("sb_instr", instr, 32'h00B50023);
        check_eq("sb_cycle", cycle_cnt, 1);
        check_eq("sb_instret", instret_cnt, 1);
        drive(1'b1, 32'h1004, 32'h00B51023, 5'd0, 32'h0, 32'h104, 32'hDEADBEEF);
        step();
        check_eq("sh_update", update, 1);
        check_eq("sh_data", mem_data, 32'h0000BEEF);
        check_eq("sh_addr", mem_addr, 32'h104);
        drive(1'b1, 32'h1008, 32'h00B52023, 5'd0, 32'h0, 32'h108, 32'hDEADBEEF);
        step();
        check_eq("sw_data", mem_data, 32'hDEADBEEF);
        drive(1'b1, 32'h100C, 32'h00B53023, 5'd0, 32'h0, 32'h10C, 32'hDEADBEEF);
        step();
        check_eq("s3_data", mem_data, 32'h0);
        check_eq("s3_wrt", mem_wrt, 1);

        // ALU, load, branch, x0 write
        drive(1'b1, 32'h1010, 32'h00500093, 5'd1, 32'h5, 32'h999, 32'h777);
        step();
        check_eq("addi_raddr", reg_addr, 1);
        check_eq("addi_rdata", reg_data, 5);
        check_eq("addi_maddr", mem_addr, 0);
        check_eq("addi_mdata", mem_data, 0);
        check_eq("addi_wrt", mem_wrt, 0);
        check_eq("addi_read", mem_read, 0);
        drive(1'b1, 32'h1014, 32'h00052503, 5'd10, 32'h1234, 32'h200, 32'h777);
        step();
        check_eq("lw_read", mem_read, 1);
        check_eq("lw_wrt", mem_wrt, 0);
        check_eq("lw_raddr", reg_addr, 10);
        check_eq("lw_rdata", reg_data, 32'h1234);
        check_eq("lw_maddr", mem_addr, 32'h200);
        check_eq("lw_mdata", mem_data, 0);
        drive(1'b1, 32'h1018, 32'h00000063, 5'd3, 32'h9, 32'h300, 32'h777);
        step();
        check_eq("br_raddr", reg_addr, 0);
        check_eq("br_rdata", reg_data, 0);
        check_eq("br_maddr", mem_addr, 0);
        check_eq("br_read", mem_read, 0);
        drive(1'b1, 32'h101C, 32'h00700013, 5'd0, 32'h7, 32'h0, 32'h0);
        step();
        check_eq("x0_update", update, 1);
        check_eq("x0_raddr", reg_addr, 0);
        check_eq("x0_rdata", reg_data, 0);
        check_eq("x0_instret", instret_cnt, 8);
        idle();
        step();
        check_eq("hold_update", update, 0);
        check_eq("hold_pc", pc, 32'h101C);
        check_eq("hold_cycle", cycle_cnt, 9);

        // Bubbles: 3 retires, 2 bubbles, 1 retire
        do_reset();
        for (int i = 0; i < 6; i++) begin
            logic v;
            v = (i < 3) || (i == 5);
            drive(v, 32'h2000 + 32'(4 * i), 32'h00100093, 5'd1, 32'(i), 32'h0, 32'h0);
            step();
            check_eq($sformatf("bub_update%0d", i), update, {63'd0, v});
        end
        check_eq("bub_instret", instret_cnt, 4);
        check_eq("bub_cycle", cycle_cnt, 6);

        // Reset overrides a pending update
        drive(1'b1, 32'h3000, 32'h00100093, 5'd1, 32'h1, 32'h0, 32'h0);
        rstn = 1'b0;
        step();
        check_zero("rstmid");
        rstn = 1'b1;

        // End-of-program
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 32'h4000 + 32'(4 * i), 32'h00100093, 5'd1, 32'(i), 32'h0, 32'h0);
            step();
        end
        drive(1'b1, 32'h4014, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        check_eq("eop_halted", halted, 1);
        check_eq("eop_update", update, 0);
        check_eq("eop_instr", instr, 0);
        check_eq("eop_instret", instret_cnt, 5);
        check_eq("eop_cycle", cycle_cnt, 6);
        check_eq("eop_timeout", timeout, 0);
        drive(1'b1, 32'h5000, 32'h00100093, 5'd1, 32'h1, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq($sformatf("eop_ign_update%0d", i), update, 0);
        end
        idle();
        for (int i = 0; i < 10; i++) step();
        check_eq("eop_frz_instret", instret_cnt, 5);
        check_eq("eop_frz_cycle", cycle_cnt, 6);
        check_eq("eop_frz_timeout", timeout, 0);
        check_eq("eop_frz_pc", pc, 32'h4010);
        rstn = 1'b0;
        step();
        check_zero("eop_rst");
        rstn = 1'b1;

        // Watchdog with no retires
        for (int i = 0; i < 7; i++) step();
        check_eq("wd7_timeout", timeout, 0);
        check_eq("wd7_cycle", cycle_cnt, 7);
        step();
        check_eq("wd8_timeout", timeout, 1);
        check_eq("wd8_cycle", cycle_cnt, 8);
        drive(1'b1, 32'h6000, 32'h00100093, 5'd1, 32'h1, 32'h0, 32'h0);
        step();
        step();
        check_eq("wd_ign_update", update, 0);
        check_eq("wd_frz_instret", instret_cnt, 0);
        check_eq("wd_frz_cycle", cycle_cnt, 8);
        check_eq("wd_halted", halted, 0);

        // A retire clears the idle count
        do_reset();
        for (int i = 0; i < 5; i++) step();
        drive(1'b1, 32'h7000, 32'h00100093, 5'd1, 32'h1, 32'h0, 32'h0);
        step();
        idle();
        for (int i = 0; i < 7; i++) step();
        check_eq("wdclr7_timeout", timeout, 0);
        step();
        check_eq("wdclr8_timeout", timeout, 1);
        check_eq("wdclr8_cycle", cycle_cnt, 14);

        // Zero word on the 8th idle cycle: HALTED wins
        do_reset();
        for (int i = 0; i < 7; i++) step();
        drive(1'b1, 32'h8000, 32'h0, 5'd0, 32'h0, 32'h0, 32'h0);
        step();
        check_eq("race_halted", halted, 1);
        check_eq("race_timeout", timeout, 0);
        check_eq("race_cycle", cycle_cnt, 8);
        idle();
        for (int i = 0; i < 3; i++) step();
        check_eq("race_timeout_late", timeout, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
